apb_reg_completer: RTL and testbench

//  APB completer (slave end) that terminates master-side APB traffic in a local register bank.

---
 rtl/apb_reg_completer_pkg.sv | 17 +
 rtl/apb_reg_completer_if.sv | 27 ++
 rtl/apb_reg_completer_reg_bank.sv | 86 ++++++++
 rtl/apb_reg_completer.sv | 120 ++++++++++++
 tb/tb_apb_reg_completer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_reg_completer_pkg.sv
// Shared types and register-map constants for the APB register completer.
// Provides the FSM state enum and the word indices of the fixed registers.
package apb_completer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int IDX_ID        = 0;
  localparam int IDX_CTRL      = 1;
  localparam int IDX_STATUS    = 2;
  localparam int FIRST_SCRATCH = 3;
  localparam int CTRL_CLR_BIT  = 0;

endpackage

// File: rtl/apb_reg_completer_if.sv
// APB bus bundle between a requester (master) and the completer (slave).
// Ports: PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PREADY/PRDATA/PSLVERR back.
interface apb_reg_completer_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_reg_completer_reg_bank.sv
// Register bank: ID/CTRL/STATUS/scratch storage, decode, error and read mux.
// Ports: PCLK, PRESETn, i_addr/i_write (decode), o_err/o_rdata, i_done/i_wr_* (commit).
module apb_reg_bank
  import apb_completer_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 13,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE  = 32'hA5B0_0001
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic                  i_done,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-3:0] i_wr_idx,
  input  logic [DATA_WIDTH-1:0] i_wr_data
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [DATA_WIDTH-1:0] CLR_MASK =
    DATA_WIDTH'(1) << CTRL_CLR_BIT;

  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_status;
  logic [DATA_WIDTH-1:0] r_scratch [FIRST_SCRATCH:NUM_REGS-1];

  logic [IW-1:0]         w_idx;
  logic                  w_ro;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_wr;

  assign w_idx = i_addr[ADDR_WIDTH-1:2];
  assign w_ro  = (w_idx == IW'(IDX_ID)) ||
                 (w_idx == IW'(IDX_STATUS));
  assign w_err = (32'(w_idx) >= 32'(NUM_REGS)) ||
                 (i_addr[1:0] != 2'b00) ||
                 (i_write && w_ro);
  assign o_err = w_err;

  always_comb begin
    w_data = '0;
    if (w_idx == IW'(IDX_ID))
      w_data = ID_VALUE;
    else if (w_idx == IW'(IDX_CTRL))
      w_data = r_ctrl;
    else if (w_idx == IW'(IDX_STATUS))
      w_data = r_status;
    for (int i = FIRST_SCRATCH; i < NUM_REGS; i++)
      if (w_idx == IW'(i))
        w_data = r_scratch[i];
  end

  assign o_rdata = (i_write || w_err) ? '0 : w_data;

  assign w_wr = i_done && i_wr_en;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_ctrl   <= '0;
      r_status <= '0;
      for (int i = FIRST_SCRATCH; i < NUM_REGS; i++)
        r_scratch[i] <= '0;
    end else begin
      if (i_done)
        r_status <= r_status + 1'b1;
      if (w_wr) begin
        if (i_wr_idx == IW'(IDX_CTRL)) begin
          // clear bit is a strobe: never stored
          r_ctrl <= i_wr_data & ~CLR_MASK;
          // clear wins over this transfer's own increment
          if (i_wr_data[CTRL_CLR_BIT])
            r_status <= '0;
        end
        for (int i = FIRST_SCRATCH; i < NUM_REGS; i++)
          if (i_wr_idx == IW'(i))
            r_scratch[i] <= i_wr_data;
      end
    end
  end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer terminating transfers in a local register bank with wait states.
// Ports: PCLK, PRESETn (sync, active low), s_apb (APB slave modport).
module apb_reg_completer
  import apb_completer_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 13,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_reg_completer_if.slave  s_apb
);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_slverr;

  logic                  w_setup;
  logic                  w_access;
  logic                  w_resp;
  logic                  w_enter_resp;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] w_dec_addr;
  logic                  w_dec_write;
  logic                  w_bank_err;
  logic [DATA_WIDTH-1:0] w_bank_rdata;

  assign w_setup  = s_apb.PSEL && !s_apb.PENABLE;
  assign w_access = s_apb.PSEL && s_apb.PENABLE;
  assign w_resp   = (r_state == ST_RESP);
  assign w_done   = w_resp && w_access;

  // zero-wait transfers enter RESP straight from setup,
  // so decode the live bus in IDLE and the captured copy after
  assign w_dec_addr  = (r_state == ST_IDLE) ? s_apb.PADDR : r_addr;
  assign w_dec_write = (r_state == ST_IDLE) ? s_apb.PWRITE : r_write;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_setup)
          w_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT:
        if (!s_apb.PSEL)
          w_next = ST_IDLE;
        else if (r_cnt == 4'd1)
          w_next = ST_RESP;
      ST_RESP:
        if (!s_apb.PSEL || s_apb.PENABLE)
          w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == ST_RESP) && !w_resp;

  always_ff @(posedge PCLK) begin
    if (!PRESETn)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_prdata <= '0;
      r_slverr <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_setup) begin
        r_addr  <= s_apb.PADDR;
        r_write <= s_apb.PWRITE;
        r_wdata <= s_apb.PWDATA;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_prdata <= w_bank_rdata;
        r_slverr <= w_bank_err;
      end
    end
  end

  apb_reg_bank #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_bank (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .i_addr    (w_dec_addr),
    .i_write   (w_dec_write),
    .o_err     (w_bank_err),
    .o_rdata   (w_bank_rdata),
    .i_done    (w_done),
    .i_wr_en   (r_write && !r_slverr),
    .i_wr_idx  (r_addr[ADDR_WIDTH-1:2]),
    .i_wr_data (r_wdata)
  );

  assign s_apb.PREADY  = w_resp;
  assign s_apb.PRDATA  = w_resp ? r_prdata : '0;
  assign s_apb.PSLVERR = w_resp && r_slverr;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: one zero-wait and one three-wait instance.
// Table of directed transfers plus sequences for abort and reset corners.
module tb_apb_reg_completer;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam logic [DW-1:0] ID = 32'hA5B0_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         psel, pen, pwr;
  logic [1:0][AW-1:0] padr;
  logic [1:0][DW-1:0] pwd;
  logic [1:0]         rdy, serr;
  logic [1:0][DW-1:0] prd;

  apb_reg_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  apb_reg_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.PSEL    = psel[0];
  assign bus0.PENABLE = pen[0];
  assign bus0.PWRITE  = pwr[0];
  assign bus0.PADDR   = padr[0];
  assign bus0.PWDATA  = pwd[0];
  assign bus1.PSEL    = psel[1];
  assign bus1.PENABLE = pen[1];
  assign bus1.PWRITE  = pwr[1];
  assign bus1.PADDR   = padr[1];
  assign bus1.PWDATA  = pwd[1];
  assign rdy  = {bus1.PREADY, bus0.PREADY};
  assign serr = {bus1.PSLVERR, bus0.PSLVERR};
  assign prd  = {bus1.PRDATA, bus0.PRDATA};

  apb_reg_completer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(16),
    .WAIT_STATES(0), .ID_VALUE(ID)
  ) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .s_apb(bus0)
  );

  apb_reg_completer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(16),
    .WAIT_STATES(3), .ID_VALUE(ID)
  ) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .s_apb(bus1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // full transfer; bus address/data are scrambled during the
  // access phase to show the captured copies are used
  task automatic xfer(input int d,
                      input logic wr,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] wd,
                      output logic [DW-1:0] rd,
                      output logic er,
                      output int waits,
                      output logic to);
    @(negedge clk);
    psel[d] = 1'b1;
    pen[d]  = 1'b0;
    pwr[d]  = wr;
    padr[d] = a;
    pwd[d]  = wd;
    @(negedge clk);
    pen[d]  = 1'b1;
    padr[d] = ~a;
    pwd[d]  = ~wd;
    waits = 0;
    to = 1'b0;
    while (!rdy[d] && !to) begin
      @(negedge clk);
      waits++;
      if (waits > 40) to = 1'b1;
    end
    rd = prd[d];
    er = serr[d];
    @(posedge clk);
    #1;
    psel[d] = 1'b0;
    pen[d]  = 1'b0;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] erd;
    logic          eer;
  } vec_t;

  vec_t tbl [19];

  logic [DW-1:0] rd;
  logic          er;
  int            wt;
  logic          to;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 13'h000C, 32'h1234_5678, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 13'h000C, 32'h0, 32'h1234_5678, 1'b0};
    tbl[2]  = '{1'b0, 13'h0000, 32'h0, ID, 1'b0};
    tbl[3]  = '{1'b1, 13'h0008, 32'hFFFF_FFFF, 32'h0, 1'b1};
    tbl[4]  = '{1'b0, 13'h0008, 32'h0, 32'd4, 1'b0};
    tbl[5]  = '{1'b0, 13'h0040, 32'h0, 32'h0, 1'b1};
    tbl[6]  = '{1'b1, 13'h000D, 32'hDEAD_BEEF, 32'h0, 1'b1};
    tbl[7]  = '{1'b0, 13'h000C, 32'h0, 32'h1234_5678, 1'b0};
    tbl[8]  = '{1'b1, 13'h0000, 32'h1, 32'h0, 1'b1};
    tbl[9]  = '{1'b1, 13'h0004, 32'h0000_00F2, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 13'h0004, 32'h0, 32'h0000_00F2, 1'b0};
    tbl[11] = '{1'b1, 13'h003C, 32'hCAFE_F00D, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 13'h003C, 32'h0, 32'hCAFE_F00D, 1'b0};
    tbl[13] = '{1'b0, 13'h003E, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{1'b1, 13'h0004, 32'h0000_0001, 32'h0, 1'b0};
    tbl[15] = '{1'b0, 13'h0008, 32'h0, 32'd0, 1'b0};
    tbl[16] = '{1'b0, 13'h0008, 32'h0, 32'd1, 1'b0};
    tbl[17] = '{1'b0, 13'h0004, 32'h0, 32'h0, 1'b0};
    tbl[18] = '{1'b0, 13'h1FFC, 32'h0, 32'h0, 1'b1};

    psel = '0;
    pen  = '0;
    pwr  = '0;
    padr = '0;
    pwd  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst pready%0d", d), 32'(rdy[d]), 32'h0);
      chk($sformatf("rst prdata%0d", d), prd[d], 32'h0);
      chk($sformatf("rst pslverr%0d", d), 32'(serr[d]), 32'h0);
    end

    for (int i = 0; i < 19; i++) begin
      xfer(0, tbl[i].wr, tbl[i].a, tbl[i].wd, rd, er, wt, to);
      chk($sformatf("v%0d timeout", i), 32'(to), 32'h0);
      chk($sformatf("v%0d prdata", i), rd, tbl[i].erd);
      chk($sformatf("v%0d pslverr", i), 32'(er), 32'(tbl[i].eer));
      chk($sformatf("v%0d waits", i), 32'(wt), 32'h0);
    end

    xfer(1, 1'b0, 13'h0000, 32'h0, rd, er, wt, to);
    chk("ws3 id waits", 32'(wt), 32'd3);
    chk("ws3 id prdata", rd, ID);
    chk("ws3 id pslverr", 32'(er), 32'h0);
    chk("ws3 pready one cycle", 32'(rdy[1]), 32'h0);

    xfer(1, 1'b1, 13'h0010, 32'h1111_1111, rd, er, wt, to);
    chk("ws3 wr waits", 32'(wt), 32'd3);
    chk("ws3 wr pslverr", 32'(er), 32'h0);

    @(negedge clk);
    psel[1] = 1'b1;
    pen[1]  = 1'b0;
    pwr[1]  = 1'b1;
    padr[1] = 13'h0010;
    pwd[1]  = 32'h2222_2222;
    @(negedge clk);
    pen[1] = 1'b1;
    @(negedge clk);
    chk("abort in wait", 32'(rdy[1]), 32'h0);
    psel[1] = 1'b0;
    pen[1]  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort pready", 32'(rdy[1]), 32'h0);
    end

    xfer(1, 1'b0, 13'h0010, 32'h0, rd, er, wt, to);
    chk("abort no write", rd, 32'h1111_1111);
    chk("abort next waits", 32'(wt), 32'd3);
    xfer(1, 1'b0, 13'h0008, 32'h0, rd, er, wt, to);
    chk("abort status", rd, 32'd3);

    @(negedge clk);
    psel[0] = 1'b1;
    pen[0]  = 1'b0;
    pwr[0]  = 1'b1;
    padr[0] = 13'h0014;
    pwd[0]  = 32'h5555_5555;
    @(negedge clk);
    pen[0] = 1'b1;
    chk("mid rst pready before", 32'(rdy[0]), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst pready", 32'(rdy[0]), 32'h0);
    chk("mid rst prdata", prd[0], 32'h0);
    chk("mid rst pslverr", 32'(serr[0]), 32'h0);
    psel[0] = 1'b0;
    pen[0]  = 1'b0;
    rst_n   = 1'b1;

    xfer(0, 1'b0, 13'h0014, 32'h0, rd, er, wt, to);
    chk("post rst no write", rd, 32'h0);
    chk("post rst waits", 32'(wt), 32'h0);
    xfer(0, 1'b0, 13'h0000, 32'h0, rd, er, wt, to);
    chk("post rst id", rd, ID);
    xfer(0, 1'b0, 13'h0008, 32'h0, rd, er, wt, to);
    chk("post rst status", rd, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
